mc_controller_ext: RTL

Parametrised multicycle MIPS control unit. It is the successor to the fixed two-decoder controller. It merges the main FSM and ALU decoding into one block and adds the I-type logic ops, bne and j. It also adds a variable-latency memory handshake (mem_req/mem_ready) and illegal-instruction detection. It sits between the instruction register and the multicycle datapath (PC, IR, register file, ALU, muxes).

---
 rtl/mc_controller_ext.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller_ext.sv
// mc_controller_ext: multicycle MIPS control unit. One FSM handles instruction
// sequencing and ALU decoding. It supports R-type, lw/sw, beq/bne,
// addi/andi/ori and j. Memory states wait on a ready handshake, and
// undecodable instructions are flagged and skipped.
`timescale 1ns/1ps
module mc_controller_ext #(
  parameter int ALUCTRL_W = 3,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pcen,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic                 extop,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BREX   = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  logic       ready;
  logic [2:0] r_alu;
  logic       r_legal;
  logic       is_mem, is_rtype, is_branch, is_itype, is_jump;
  logic       pcwrite, branch, taken;
  logic [2:0] alu3;

  // With waiting disabled every memory access completes in its first cycle.
  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign is_rtype  = (op == OP_R);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_itype  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_jump   = (op == OP_J);
  assign taken     = (op == OP_BNE) ? ~zero : zero;

  // R-type function decode: ALU code plus a legality flag for unmapped functs.
  always_comb begin
    r_alu   = ALU_ADD;
    r_legal = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_legal = 1'b0;
    endcase
  end

  // State sequencing: memory states hold until ready, reset returns to FETCH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (is_mem)                    state_q <= S_MEMADR;
          else if (is_rtype && r_legal)  state_q <= S_REX;
          else if (is_branch)            state_q <= S_BREX;
          else if (is_itype)             state_q <= S_IEX;
          else if (is_jump)              state_q <= S_JEX;
          else                           state_q <= S_FETCH;
        end
        S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (ready) state_q <= S_FETCH;
        S_REX:    state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_BREX:   state_q <= S_FETCH;
        S_IEX:    state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_JEX:    state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode, with mem_ready gating in FETCH and reset masking the
  // side-effecting strobes so an in-flight write is dropped immediately.
  // NOTE: every output gets a default before the case so no latch is inferred
  // for states that leave a signal untouched.
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    extop    = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu3     = ALU_ADD;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = ready;
        pcwrite = ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~(is_mem | (is_rtype & r_legal) | is_branch | is_itype | is_jump);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_req  = 1'b1;
        memwrite = 1'b1;
      end
      S_REX: begin
        alusrca = 1'b1;
        alu3    = r_alu;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BREX: begin
        alusrca = 1'b1;
        alu3    = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_ANDI) begin
          alu3  = ALU_AND;
          extop = 1'b1;
        end else if (op == OP_ORI) begin
          alu3  = ALU_OR;
          extop = 1'b1;
        end
      end
      S_IWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
  end

  assign pcen       = pcwrite | (branch & taken);
  assign alucontrol = ALUCTRL_W'(alu3);
  assign state      = state_q;

endmodule
